// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - NS/EW intersection phase controller with prescaled timebase
module traffic_phase_ctrl #(
  parameter int         PRESCALE     = 50,
  parameter logic [7:0] NS_GREEN_MIN = 8'd20,
  parameter logic [7:0] EW_GREEN_T   = 8'd12,
  parameter logic [7:0] YELLOW_T     = 8'd4,
  parameter logic [7:0] ALL_RED_T    = 8'd2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ew_sensor,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] phase,
  output logic       tick
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] ALL_RED_A = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] ALL_RED_B = 3'd5;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  logic [2:0]    phase_q, phase_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic          ped_pend_q, ped_pend_d;
  logic          walk_q, walk_d;
  logic          tick_w;
  logic [7:0]    dur;
  logic          enter_ew, leave_ew;

  assign tick_w = enable && (presc_q == PRESC_LAST);

  // State register: phase, timebase, pedestrian latch and walk lamp
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q    <= ALL_RED_B;
      presc_q    <= '0;
      tcnt_q     <= 8'd0;
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      presc_q    <= presc_d;
      tcnt_q     <= tcnt_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
    end
  end

  // Next state: prescaler wrap, tick counting and phase advance on tick edges
  always_comb begin
    presc_d = presc_q;
    if (enable) presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;

    case (phase_q)
      NS_GREEN:             dur = NS_GREEN_MIN;
      NS_YELLOW, EW_YELLOW: dur = YELLOW_T;
      EW_GREEN:             dur = EW_GREEN_T;
      default:              dur = ALL_RED_T;
    endcase

    phase_d = phase_q;
    tcnt_d  = tcnt_q;
    if (phase_q > ALL_RED_B) begin
      // Illegal code: recover to the clearance phase regardless of enable
      phase_d = ALL_RED_B;
      tcnt_d  = 8'd0;
    end else if (tick_w) begin
      if (tcnt_q == dur - 8'd1) begin
        // NS green waits here (counter saturated) until someone asks for service
        if (phase_q != NS_GREEN || ew_sensor || ped_pend_q) begin
          phase_d = (phase_q == ALL_RED_B) ? NS_GREEN : phase_q + 3'd1;
          tcnt_d  = 8'd0;
        end
      end else begin
        tcnt_d = tcnt_q + 8'd1;
      end
    end

    enter_ew = (phase_d == EW_GREEN) && (phase_q != EW_GREEN);
    leave_ew = (phase_q == EW_GREEN) && (phase_d != EW_GREEN);

    // A new press on the serving edge wins so it is not lost
    ped_pend_d = ped_req | (ped_pend_q & ~enter_ew);
    if (enter_ew)      walk_d = ped_pend_q;
    else if (leave_ew) walk_d = 1'b0;
    else               walk_d = walk_q;
  end

  // Outputs: lights decoded from the phase register only
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    case (phase_q)
      NS_GREEN:  ns_light = GREEN;
      NS_YELLOW: ns_light = YELLOW;
      EW_GREEN:  ew_light = GREEN;
      EW_YELLOW: ew_light = YELLOW;
      default: begin
        ns_light = RED;
        ew_light = RED;
      end
    endcase
    walk     = walk_q;
    ped_pend = ped_pend_q;
    phase    = phase_q;
    tick     = tick_w;
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - scoreboard bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       ew_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, ped_pend, tick;

  traffic_phase_ctrl #(
    .PRESCALE(2), .NS_GREEN_MIN(8'd3), .EW_GREEN_T(8'd4), .YELLOW_T(8'd2), .ALL_RED_T(8'd1)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .ew_sensor(ew_sensor), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .ped_pend(ped_pend),
    .phase(phase), .tick(tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] ph;
    int         len;
    int         walk_cycles;
  } seg_t;

  seg_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_ns(input logic [2:0] p);
    case (p)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(input logic [2:0] p);
    case (p)
      3'd3:    return 3'b001;
      3'd4:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Monitor: per-cycle invariants, and segment (phase, length, walk cycles) scoreboard
  logic [2:0] cur_ph;
  int         seg_len, seg_walk;
  bit         seg_valid = 1'b0;
  always @(negedge clock) begin
    seg_t e;
    if (mon_on) begin
      check_val("legal_phase", {31'd0, phase > 3'd5}, 32'd0);
      check_val("ns_light", {29'd0, ns_light}, {29'd0, exp_ns(phase)});
      check_val("ew_light", {29'd0, ew_light}, {29'd0, exp_ew(phase)});
      if (walk) check_val("walk_outside_ew", {29'd0, phase}, 32'd3);
      if (!seg_valid) begin
        cur_ph = phase; seg_len = 1; seg_walk = int'(walk); seg_valid = 1'b1;
      end else if (phase == cur_ph) begin
        seg_len++; seg_walk += int'(walk);
      end else begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("seg_phase", {29'd0, cur_ph}, {29'd0, e.ph});
          check_val("seg_len", seg_len, e.len);
          check_val("seg_walk", seg_walk, e.walk_cycles);
        end
        cur_ph = phase; seg_len = 1; seg_walk = int'(walk);
      end
    end else begin
      seg_valid = 1'b0;
    end
  end

  task automatic push(input logic [2:0] p, input int len, input int wc);
    seg_t s;
    s.ph = p; s.len = len; s.walk_cycles = wc;
    exp_q.push_back(s);
  endtask

  task automatic push_round(input int walk8, input int ew_len);
    push(3'd0, 6, 0); push(3'd1, 4, 0); push(3'd2, 2, 0);
    push(3'd3, ew_len, walk8); push(3'd4, 4, 0); push(3'd5, 2, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_phase"}, {29'd0, phase}, 32'd5);
    check_val({tag, "_ns"}, {29'd0, ns_light}, 32'b100);
    check_val({tag, "_ew"}, {29'd0, ew_light}, 32'b100);
    check_val({tag, "_walk"}, {31'd0, walk}, 32'd0);
    check_val({tag, "_pend"}, {31'd0, ped_pend}, 32'd0);
    check_val({tag, "_tick"}, {31'd0, tick}, 32'd0);
  endtask

  task automatic do_reset(input logic ew);
    mon_on = 1'b0;
    exp_q.delete();
    ped_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1 check_reset_vals("rst");
    ew_sensor = ew;
    enable = 1'b1;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    mon_on = 1'b1;
    push(3'd5, 2, 0);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
    check_val({tag, "_drain"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_phase(input logic [2:0] p, input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clock);
      i++;
    end while (phase != p && i < budget);
    check_val("wait_phase", {29'd0, phase}, {29'd0, p});
  endtask

  initial begin
    // Idle: phase 5 for 2 cycles, then NS green held
    do_reset(1'b0);
    wait_empty("idle", 20);
    repeat (60) @(negedge clock);
    check_val("hold_phase", {29'd0, phase}, 32'd0);
    check_val("hold_ns", {29'd0, ns_light}, 32'b001);
    check_val("hold_ew", {29'd0, ew_light}, 32'b100);

    // Continuous EW demand: full cycles 6,4,2,8,4,2
    do_reset(1'b1);
    push_round(0, 8);
    push_round(0, 8);
    wait_empty("cycle", 200);

    // Pedestrian pulse during NS green
    do_reset(1'b0);
    push_round(8, 8);
    wait_phase(3'd0, 20);
    ped_req = 1'b1;
    @(negedge clock);
    ped_req = 1'b0;
    check_val("ped_latched", {31'd0, ped_pend}, 32'd1);
    wait_phase(3'd3, 40);
    check_val("ped_served", {31'd0, ped_pend}, 32'd0);
    wait_empty("ped", 100);

    // Press on the very edge entering EW green is deferred one round
    do_reset(1'b1);
    push_round(0, 8);
    push_round(8, 8);
    wait_phase(3'd2, 40);
    @(negedge clock);
    ped_req = 1'b1;
    @(negedge clock);
    ped_req = 1'b0;
    check_val("edge_phase", {29'd0, phase}, 32'd3);
    check_val("edge_walk", {31'd0, walk}, 32'd0);
    check_val("edge_pend", {31'd0, ped_pend}, 32'd1);
    wait_empty("edge", 200);

    // Freeze 10 cycles mid EW green
    do_reset(1'b1);
    push_round(0, 18);
    wait_phase(3'd3, 40);
    repeat (2) @(negedge clock);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_val("frz_tick", {31'd0, tick}, 32'd0);
      check_val("frz_phase", {29'd0, phase}, 32'd3);
    end
    enable = 1'b1;
    wait_empty("freeze", 100);

    // Reset mid NS yellow
    do_reset(1'b1);
    push(3'd0, 6, 0);
    wait_phase(3'd1, 40);
    @(negedge clock);
    mon_on = 1'b0;
    exp_q.delete();
    #2 reset = 1'b1;
    #1 check_reset_vals("async");
    @(posedge clock);
    #1 reset = 1'b0;
    mon_on = 1'b1;
    push(3'd5, 2, 0); push(3'd0, 6, 0); push(3'd1, 4, 0);
    wait_empty("rst_mid", 60);

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Two-road (NS/EW) intersection phase controller with an internal prescaled timebase.
- Sequences six light phases with per-phase tick durations.
- Holds NS green until EW traffic or a pedestrian requests service.
- Latches pedestrian requests and grants a walk interval during EW green.
- Top-level controller above the board's light and display drivers.

Parameters:
PRESCALE, 50, clock cycles per tick (>=1)
NS_GREEN_MIN, 8'd20, minimum NS green duration in ticks (1..255)
EW_GREEN_T, 8'd12, fixed EW green duration in ticks (1..255)
YELLOW_T, 8'd4, yellow duration in ticks for either road (1..255)
ALL_RED_T, 8'd2, all-red clearance duration in ticks (1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clock clock
enable  in  1  1 = run timebase; 0 = freeze prescaler, tick counter and phase
ew_sensor  in  1  level: vehicle waiting on EW road
ped_req  in  1  pedestrian button, any-length pulse
ns_light  out  3  {red,yellow,green} one-hot for NS road
ew_light  out  3  {red,yellow,green} one-hot for EW road
walk  out  1  pedestrian walk lamp
ped_pend  out  1  pedestrian request latched, not yet served
phase  out  3  current phase code
tick  out  1  timebase tick, one-cycle pulse

Behaviour:
- Phase codes and order:
  - 0 NS_GREEN
  - 1 NS_YELLOW
  - 2 ALL_RED_A
  - 3 EW_GREEN
  - 4 EW_YELLOW
  - 5 ALL_RED_B
  - Order: 5 -> 0 -> 1 -> 2 -> 3 -> 4 -> 5. Codes 6 and 7 are illegal and go to 5 on the next edge.
- Reset (async): phase=5, prescaler=0, tick counter=0, ped_pend=0, walk=0, ns_light=3'b100, ew_light=3'b100, tick=0.
- Prescaler: counts 0..PRESCALE-1 while enable=1 and wraps to 0. tick = enable && prescaler==PRESCALE-1 (combinational from registers).
- Tick counter (8 bit): increments on each tick edge. Clears to 0 on every phase transition.
- Timed phases (1, 2, 3, 4, 5) end on the tick edge where tick counter == duration-1. Durations: yellow phases use YELLOW_T, all-red phases use ALL_RED_T, phase 3 uses EW_GREEN_T. With enable held high, each timed phase lasts exactly duration*PRESCALE cycles.
- NS_GREEN:
  - Min-time reached when tick counter == NS_GREEN_MIN-1; the counter then saturates at that value.
  - Transition to 1 occurs on a tick edge where min-time is reached and (ew_sensor || ped_pend) is sampled high.
  - With no request, the phase holds indefinitely.
  - A request arriving mid-hold is served at the next tick edge.
- Lights are Moore-decoded from the phase register and change on the same edge as the phase:
  - phase 0: NS green, EW red
  - phase 1: NS yellow, EW red
  - phase 3: NS red, EW green
  - phase 4: NS red, EW yellow
  - phases 2 and 5: both red
  - Never any green or yellow on both roads at once.
- Pedestrian handling:
  - ped_pend sets on any cycle with ped_req=1 (reset excepted).
  - On the edge entering phase 3: walk<=ped_pend and ped_pend<=0.
  - If ped_req=1 on that same edge, ped_pend remains 1 (set wins) and is served next cycle round.
  - walk clears on the edge leaving phase 3.
- enable=0: all state frozen, outputs hold. ped_pend still latches requests. Resumes exactly where it stopped.
- Reset mid-phase: immediate return to reset values; cycle restarts from ALL_RED_B.

Test Plan (PRESCALE=2, NS_GREEN_MIN=3, EW_GREEN_T=4, YELLOW_T=2, ALL_RED_T=1):
- Reset, release, enable=1, no requests -> phase 5 for 2 cycles, then phase 0 and held for 50+ cycles; ns_light=001, ew_light=100.
- ew_sensor=1 from release -> phases 0,1,2,3,4,5 last 6,4,2,8,4,2 cycles; then repeat from phase 0.
- Pulse ped_req 1 cycle during phase 0, ew_sensor=0 -> ped_pend=1; after min-time phase 1; in phase 3 walk=1 for 8 cycles and ped_pend=0.
- ped_req=1 on the edge entering phase 3 -> walk=0 this round and ped_pend stays 1; walk=1 on the following EW green.
- enable=0 for 10 cycles mid phase 3 -> phase, lights and tick counter frozen; total phase 3 length = 18 cycles.
- Assert reset mid phase 1 -> outputs immediately match reset values; after release phase 5 then 0; phase never reads 6 or 7.
